// File: rtl/time_cmd_parser.sv
// Parses "T"/"t" + HHMMSSCC + CR/LF from the UART RX byte stream into binary time-load values.
// Define PARSER_TIMEOUT_EN to abort a command after TIMEOUT_CYCLES idle clocks.
module time_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic [6:0] set_msec,
  output logic       set_valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DIGITS, TERM} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [31:0] bcd, bcd_nx;
  logic        load, err_nx;
  logic        timeout;
  logic        is_t, is_dig, is_term;
  logic [6:0]  hour_f, min_f, sec_f, msec_f;
  logic        in_range;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int unsigned     GAP_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [GAP_W-1:0] gap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      gap <= '0;
    else if (rx_valid || state == IDLE)
      gap <= '0;
    else
      gap <= gap + GAP_W'(1);
  end

  assign timeout = (state != IDLE) && (gap == GAP_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign is_t    = (rx_data == 8'h54) || (rx_data == 8'h74);
  assign is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);

  // Range check on the full two-digit value so e.g. minute 99 cannot alias into range.
  assign hour_f = {3'b0, bcd[31:28]} * 7'd10 + {3'b0, bcd[27:24]};
  assign min_f  = {3'b0, bcd[23:20]} * 7'd10 + {3'b0, bcd[19:16]};
  assign sec_f  = {3'b0, bcd[15:12]} * 7'd10 + {3'b0, bcd[11:8]};
  assign msec_f = {3'b0, bcd[7:4]}   * 7'd10 + {3'b0, bcd[3:0]};
  assign in_range = (hour_f <= 7'd23) && (min_f <= 7'd59) &&
                    (sec_f <= 7'd59) && (msec_f <= 7'd99);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bcd_nx   = bcd;
    load     = 1'b0;
    err_nx   = 1'b0;
    if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (is_t) begin
            state_nx = DIGITS;
            cnt_nx   = '0;
            bcd_nx   = '0;
          end
        end
        DIGITS: begin
          if (is_dig) begin
            bcd_nx = {bcd[27:0], rx_data[3:0]};
            cnt_nx = cnt + 3'd1;
            if (cnt == 3'd7)
              state_nx = TERM;
          end else if (is_t) begin
            err_nx = 1'b1;
            cnt_nx = '0;
            bcd_nx = '0;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
        TERM: begin
          if (is_term) begin
            load     = in_range;
            err_nx   = !in_range;
            state_nx = IDLE;
          end else if (is_t) begin
            err_nx   = 1'b1;
            state_nx = DIGITS;
            cnt_nx   = '0;
            bcd_nx   = '0;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end else if (timeout) begin
      err_nx   = 1'b1;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bcd       <= '0;
      set_hour  <= '0;
      set_min   <= '0;
      set_sec   <= '0;
      set_msec  <= '0;
      set_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bcd       <= bcd_nx;
      set_valid <= load;
      err       <= err_nx;
      if (load) begin
        set_hour <= hour_f[4:0];
        set_min  <= min_f[5:0];
        set_sec  <= sec_f[5:0];
        set_msec <= msec_f;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
